reg_bank_arbiter: RTL and testbench

Round-robin arbiter and sequencer that shares a bank of 16-bit load/reset registers among several requesters. Each requester issues single-word read or write transactions through a req/gnt/ack handshake. The block serialises them onto the bank one at a time, so the bank has a single write port (per-register load enable) and a single read port. It sits between the processing units and the register storage, and is the only agent that drives the registers' load and data inputs.

---
 rtl/reg_bank_arbiter.sv | 163 ++++++++++++++++
 tb/tb_reg_bank_arbiter.sv | 221 ++++++++++++++++++++++
 2 files changed

// File: rtl/reg_bank_arbiter.sv
// reg_bank_arbiter: round-robin arbiter/sequencer that shares a bank of
// load/reset registers among NUM_REQ requesters. Transactions are serialised
// through IDLE -> SERVE -> ACK, so the bank has one write port and one read port.
//
// Ports:
//   i_clk, i_reset     clock, async active-high reset (also clears the bank)
//   i_req/i_we         per-requester request level and op (1 write, 0 read)
//   i_addr/i_wdata     per-requester address / write data, packed by requester
//   o_gnt              one-hot grant, held across SERVE and ACK
//   o_ack              one-cycle completion pulse (ACK state)
//   o_rdata            last read result, valid with o_ack for a read
//   o_busy             state != IDLE
//   o_regs             flat bank contents, reg k at [k*WIDTH +: WIDTH]

module reg_bank_cell #(
  parameter int WIDTH = 16
) (
  input  logic             i_clk,
  input  logic             i_reset,
  input  logic             i_ld,
  input  logic [WIDTH-1:0] i_d,
  output logic [WIDTH-1:0] o_q
);
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset)   o_q <= '0;
    else if (i_ld) o_q <= i_d;
endmodule

module reg_bank_arbiter #(
  parameter int NUM_REQ = 4,
  parameter int WIDTH   = 16,
  parameter int ADDR_W  = 3
) (
  input  logic                        i_clk,
  input  logic                        i_reset,
  input  logic [NUM_REQ-1:0]          i_req,
  input  logic [NUM_REQ-1:0]          i_we,
  input  logic [NUM_REQ*ADDR_W-1:0]   i_addr,
  input  logic [NUM_REQ*WIDTH-1:0]    i_wdata,
  output logic [NUM_REQ-1:0]          o_gnt,
  output logic                        o_ack,
  output logic [WIDTH-1:0]            o_rdata,
  output logic                        o_busy,
  output logic [(2**ADDR_W)*WIDTH-1:0] o_regs
);
  localparam int NREG  = 2**ADDR_W;
  localparam int PTR_W = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1;

  typedef enum logic [1:0] {S_IDLE, S_SERVE, S_ACK} state_t;

  typedef struct packed {
    logic              we;
    logic [ADDR_W-1:0] addr;
    logic [WIDTH-1:0]  wdata;
    logic [PTR_W-1:0]  idx;
  } txn_t;

  state_t r_state, w_next;
  txn_t   r_txn;
  logic [PTR_W-1:0] r_ptr;
  logic [WIDTH-1:0] r_rdata;

  logic [NUM_REQ-1:0][ADDR_W-1:0] w_addr_a;
  logic [NUM_REQ-1:0][WIDTH-1:0]  w_wdata_a;
  logic [NREG-1:0][WIDTH-1:0]     w_q;
  logic [2*NUM_REQ-1:0]           w_dbl;
  logic [NUM_REQ-1:0]             w_rot;
  logic [PTR_W:0]                 w_off, w_sum;
  logic [PTR_W-1:0]               w_win;
  logic                           w_found;
  logic [NUM_REQ-1:0]             w_gnt;
  logic                           w_busy, w_ack;

  assign w_addr_a  = i_addr;
  assign w_wdata_a = i_wdata;

  // Rotate requests so bit 0 is the requester at ptr; the first set bit of the
  // rotated vector is the round-robin winner, then undo the rotation mod NUM_REQ.
  assign w_dbl = {i_req, i_req} >> r_ptr;
  assign w_rot = w_dbl[NUM_REQ-1:0];

  always_comb begin
    w_found = 1'b0;
    w_off   = '0;
    for (int k = 0; k < NUM_REQ; k++)
      if (!w_found && w_rot[k]) begin
        w_found = 1'b1;
        w_off   = (PTR_W+1)'(k);
      end
    w_sum = {1'b0, r_ptr} + w_off;
    if (w_sum >= (PTR_W+1)'(NUM_REQ)) w_sum = w_sum - (PTR_W+1)'(NUM_REQ);
    w_win = w_sum[PTR_W-1:0];
  end

  // state register
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) r_state <= S_IDLE;
    else         r_state <= w_next;

  // next state
  always_comb begin
    w_next = S_IDLE;
    case (r_state)
      S_IDLE:  w_next = w_found ? S_SERVE : S_IDLE;
      S_SERVE: w_next = S_ACK;
      S_ACK:   w_next = S_IDLE;
      default: w_next = S_IDLE;
    endcase
  end

  // outputs: grant follows the latched winner for the whole transaction
  always_comb begin
    w_busy = (r_state != S_IDLE);
    w_ack  = (r_state == S_ACK);
    w_gnt  = '0;
    for (int i = 0; i < NUM_REQ; i++)
      w_gnt[i] = w_busy && (r_txn.idx == PTR_W'(i));
  end

  // datapath: operands latched at grant so later input changes cannot leak in
  always_ff @(posedge i_clk or posedge i_reset)
    if (i_reset) begin
      r_txn   <= '0;
      r_ptr   <= '0;
      r_rdata <= '0;
    end else begin
      case (r_state)
        S_IDLE:
          if (w_found) begin
            r_txn.we    <= i_we[w_win];
            r_txn.addr  <= w_addr_a[w_win];
            r_txn.wdata <= w_wdata_a[w_win];
            r_txn.idx   <= w_win;
          end
        S_SERVE:
          if (!r_txn.we) r_rdata <= w_q[r_txn.addr];
        S_ACK:
          r_ptr <= (r_txn.idx == PTR_W'(NUM_REQ-1)) ? '0 : r_txn.idx + 1'b1;
        default: ;
      endcase
    end

  genvar k;
  generate
    for (k = 0; k < NREG; k++) begin : g_bank
      logic w_ld;
      assign w_ld = (r_state == S_SERVE) && r_txn.we && (r_txn.addr == ADDR_W'(k));
      reg_bank_cell #(.WIDTH(WIDTH)) u_cell (
        .i_clk  (i_clk),
        .i_reset(i_reset),
        .i_ld   (w_ld),
        .i_d    (r_txn.wdata),
        .o_q    (w_q[k])
      );
    end
  endgenerate

  assign o_gnt   = w_gnt;
  assign o_ack   = w_ack;
  assign o_busy  = w_busy;
  assign o_rdata = r_rdata;
  assign o_regs  = w_q;
endmodule

// File: tb/tb_reg_bank_arbiter.sv
module tb_reg_bank_arbiter;
  logic         clk = 1'b0;
  logic         reset;
  logic [3:0]   req, we, keep;
  logic [11:0]  addr;
  logic [63:0]  wdata;
  logic [3:0]   gnt;
  logic         ack, busy;
  logic [15:0]  rdata;
  logic [127:0] regs;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gcnt = 0;
  logic prev_ack = 1'b0;

  typedef struct {
    int         idx;
    bit         we;
    int         addr;
    logic [15:0] data;
  } exp_t;
  exp_t sbq[$];
  int   ack_cyc[$];

  reg_bank_arbiter #(.NUM_REQ(4), .WIDTH(16), .ADDR_W(3)) dut (
    .i_clk(clk), .i_reset(reset), .i_req(req), .i_we(we), .i_addr(addr),
    .i_wdata(wdata), .o_gnt(gnt), .o_ack(ack), .o_rdata(rdata), .o_busy(busy),
    .o_regs(regs)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc++;

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s act=%0h exp=%0h", name, act, exp);
    end
  endtask

  // monitor: pops the scoreboard on every ack, and checks pulse widths
  always @(negedge clk) begin
    if (reset) begin
      gcnt = 0;
      prev_ack = 1'b0;
    end else begin
      if (gnt != 4'b0) gcnt++;
      else if (gcnt != 0) begin
        chk("gnt_len", gcnt, 2);
        gcnt = 0;
      end
      if (ack) begin
        ack_cyc.push_back(cyc);
        chk("ack_single", prev_ack, 0);
        if (sbq.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL unexpected_ack gnt=%b", gnt);
        end else begin
          exp_t e;
          e = sbq.pop_front();
          chk("ack_gnt", gnt, 4'b1 << e.idx);
          if (e.we) chk("wr_reg", regs[e.addr*16 +: 16], e.data);
          else      chk("rd_data", rdata, e.data);
        end
      end
      prev_ack = ack;
    end
  end

  task automatic push(input int i, input bit w, input int a, input logic [15:0] d);
    exp_t e;
    e.idx = i; e.we = w; e.addr = a; e.data = d;
    sbq.push_back(e);
  endtask

  task automatic set_req(input int i, input bit w, input int a, input logic [15:0] d);
    req[i] = 1'b1;
    we[i]  = w;
    addr[i*3 +: 3]   = 3'(a);
    wdata[i*16 +: 16] = d;
  endtask

  // wait for n acks; each acked requester drops req unless kept, all drop on the last
  task automatic run(input int n);
    int got = 0;
    int t = 0;
    logic [3:0] drop;
    while (got < n && t < 60) begin
      @(negedge clk);
      t++;
      drop = 4'b0;
      if (ack) begin
        got++;
        drop = (got == n) ? 4'hF : (gnt & ~keep);
      end
      @(posedge clk); #1;
      req = req & ~drop;
    end
    if (got < n) begin
      checks++;
      errors++;
      $display("FAIL run_timeout got=%0d need=%0d", got, n);
    end
  endtask

  initial begin
    int t;
    logic [127:0] exp_bank;
    keep  = 4'b0;
    reset = 1'b1;
    req   = 4'($urandom);
    we    = 4'($urandom);
    addr  = 12'($urandom);
    wdata = {$urandom, $urandom};
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_gnt", gnt, 0);
    chk("rst_ack", ack, 0);
    chk("rst_busy", busy, 0);
    chk("rst_rdata", rdata, 0);
    chk("rst_regs", regs, 0);
    req = 4'b0;
    @(posedge clk); #1;
    reset = 1'b0;

    // single write then read
    push(0, 1, 3, 16'hAAAA);
    set_req(0, 1, 3, 16'hAAAA);
    run(1);
    chk("wr_reg3", regs[3*16 +: 16], 16'hAAAA);
    push(0, 0, 3, 16'hAAAA);
    set_req(0, 0, 3, 16'h0);
    run(1);

    // async reset between edges
    @(negedge clk); #2;
    reset = 1'b1;
    #1;
    chk("arst_regs", regs, 0);
    chk("arst_rdata", rdata, 0);
    chk("arst_busy", busy, 0);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;

    // four simultaneous writes, ptr=0 -> order 0,1,2,3
    ack_cyc.delete();
    for (int i = 0; i < 4; i++) begin
      push(i, 1, i, 16'h1234 + 16'(i));
      set_req(i, 1, i, 16'h1234 + 16'(i));
    end
    run(4);
    if (ack_cyc.size() >= 4) begin
      for (int i = 1; i < 4; i++) chk("ack_spacing", ack_cyc[i] - ack_cyc[i-1], 3);
    end else begin
      checks++; errors++;
      $display("FAIL ack_count act=%0d exp=4", ack_cyc.size());
    end
    for (int i = 0; i < 4; i++) chk("four_reg", regs[i*16 +: 16], 16'h1234 + 16'(i));

    // fairness: 0 and 2 held, ptr=0 -> 0,2,0,2
    keep = 4'b0101;
    push(0, 0, 0, 16'h1234); push(2, 0, 2, 16'h1236);
    push(0, 0, 0, 16'h1234); push(2, 0, 2, 16'h1236);
    set_req(0, 0, 0, 16'h0);
    set_req(2, 0, 2, 16'h0);
    run(4);
    keep = 4'b0;

    // operand stability: ptr=3, requester 1 wins, inputs disturbed after grant
    push(1, 1, 5, 16'h5555);
    set_req(1, 1, 5, 16'h5555);
    t = 0;
    do begin @(negedge clk); t++; end while (!gnt[1] && t < 20);
    chk("stab_gnt", gnt, 4'b0010);
    #1;
    addr[5:3]   = 3'd6;
    wdata[31:16] = 16'hBEEF;
    req[1]      = 1'b0;
    run(1);
    exp_bank = '0;
    for (int i = 0; i < 4; i++) exp_bank[i*16 +: 16] = 16'h1234 + 16'(i);
    exp_bank[5*16 +: 16] = 16'h5555;
    chk("stab_bank", regs, exp_bank);

    // reset during SERVE of a write to reg7 (ptr=2, requester 3 wins)
    set_req(3, 1, 7, 16'hFFFF);
    t = 0;
    do begin @(negedge clk); t++; end while (!gnt[3] && t < 20);
    chk("mid_gnt", gnt, 4'b1000);
    #2;
    reset = 1'b1;
    #1;
    chk("mid_gnt_clr", gnt, 0);
    chk("mid_ack_clr", ack, 0);
    chk("mid_busy_clr", busy, 0);
    chk("mid_regs", regs, 0);
    req = 4'b0;
    repeat (2) @(posedge clk);
    #1;
    chk("mid_reg7", regs[7*16 +: 16], 0);
    reset = 1'b0;

    // fresh traffic after reset: ptr=0 -> 2 wins; then ptr=3 -> 1 wins
    push(2, 1, 7, 16'h0F0F);
    set_req(2, 1, 7, 16'h0F0F);
    run(1);
    push(1, 0, 7, 16'h0F0F);
    set_req(1, 0, 7, 16'h0);
    run(1);

    repeat (3) @(posedge clk);
    chk("sb_empty", sbq.size(), 0);
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
